// File: rtl/gp_regfile_sweep_if.sv
// ============================================================================
// Module      : gp_regfile_sweep_if
// Description : Write, ALU read, data-bus read and clear-sweep signals of the
//               general-purpose register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gp_regfile_sweep_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
);
    localparam int AW = $clog2(DEPTH);

    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  bus_rd_en;
    logic [AW-1:0]         bus_rd_addr;
    logic [DATA_WIDTH-1:0] bus_rd_data;
    logic                  bus_rd_valid;
    logic [AW-1:0]         alu_a_addr;
    logic [AW-1:0]         alu_b_addr;
    logic [DATA_WIDTH-1:0] alu_a_data;
    logic [DATA_WIDTH-1:0] alu_b_data;
    logic                  clear_start;
    logic                  busy;
    logic                  clear_done;

    modport master (
        output wr_en, wr_addr, wr_data, bus_rd_en, bus_rd_addr,
               alu_a_addr, alu_b_addr, clear_start,
        input  bus_rd_data, bus_rd_valid, alu_a_data, alu_b_data,
               busy, clear_done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, bus_rd_en, bus_rd_addr,
               alu_a_addr, alu_b_addr, clear_start,
        output bus_rd_data, bus_rd_valid, alu_a_data, alu_b_data,
               busy, clear_done
    );
endinterface

`default_nettype wire

// File: rtl/gp_regfile_sweep.sv
// ============================================================================
// Module      : gp_regfile_sweep
// Description : Parametrised GPR file: one write port, two combinational ALU
//               read ports, a registered bus read port and a one-entry-per-
//               cycle clear sweep. Optional macro GPR_WRITE_BYPASS_EN enables
//               same-cycle write-to-read forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gp_regfile_sweep #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int ZERO_REG   = 0
) (
    input  wire logic         clock,
    input  wire logic         reset,
    gp_regfile_sweep_if.slave bus
);
    localparam int            AW     = $clog2(DEPTH);
    localparam logic [AW-1:0] C_LAST = AW'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                r_state;
    logic [AW-1:0]         r_idx;
    logic                  r_busy;
    logic                  r_clear_done;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_bus_rd_data;
    logic                  r_bus_rd_valid;

    logic                  w_wr_ok;
    logic [DATA_WIDTH-1:0] w_alu_a;
    logic [DATA_WIDTH-1:0] w_alu_b;
    logic [DATA_WIDTH-1:0] w_bus_rd;

    // Writes are dropped during a sweep and, with ZERO_REG, to entry 0.
    assign w_wr_ok = bus.wr_en && !r_busy &&
                     !((ZERO_REG != 0) && (bus.wr_addr == '0));

    always_comb begin
        w_alu_a  = r_mem[bus.alu_a_addr];
        w_alu_b  = r_mem[bus.alu_b_addr];
        w_bus_rd = r_mem[bus.bus_rd_addr];
`ifdef GPR_WRITE_BYPASS_EN
        if (w_wr_ok && (bus.wr_addr == bus.alu_a_addr))  w_alu_a  = bus.wr_data;
        if (w_wr_ok && (bus.wr_addr == bus.alu_b_addr))  w_alu_b  = bus.wr_data;
        if (w_wr_ok && (bus.wr_addr == bus.bus_rd_addr)) w_bus_rd = bus.wr_data;
`endif
        if (ZERO_REG != 0) begin
            if (bus.alu_a_addr == '0)  w_alu_a  = '0;
            if (bus.alu_b_addr == '0)  w_alu_b  = '0;
            if (bus.bus_rd_addr == '0) w_bus_rd = '0;
        end
    end

    // Storage array: the sweep owns the array while busy, so it never
    // competes with an accepted write.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (r_state == ST_CLEAR) begin
            r_mem[r_idx] <= '0;
        end else if (w_wr_ok) begin
            r_mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_bus_rd_data  <= '0;
            r_bus_rd_valid <= 1'b0;
        end else begin
            r_bus_rd_valid <= bus.bus_rd_en;
            if (bus.bus_rd_en) begin
                r_bus_rd_data <= w_bus_rd;
            end
        end
    end

    // Clear-sweep FSM; busy and clear_done are registered alongside the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_busy       <= 1'b0;
            r_clear_done <= 1'b0;
        end else begin
            r_clear_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.clear_start) begin
                        r_state <= ST_CLEAR;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == C_LAST) begin
                        r_state      <= ST_IDLE;
                        r_busy       <= 1'b0;
                        r_clear_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.alu_a_data   = w_alu_a;
    assign bus.alu_b_data   = w_alu_b;
    assign bus.bus_rd_data  = r_bus_rd_data;
    assign bus.bus_rd_valid = r_bus_rd_valid;
    assign bus.busy         = r_busy;
    assign bus.clear_done   = r_clear_done;

endmodule

`default_nettype wire

// File: tb/tb_gp_regfile_sweep.sv
// ============================================================================
// Module      : tb_gp_regfile_sweep
// Description : Drives a ZERO_REG=0 and a ZERO_REG=1 instance with identical
//               stimulus and compares both against an array-based model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gp_regfile_sweep;
    localparam int DW = 8;
    localparam int DEPTH = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    gp_regfile_sweep_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) ifz ();
    gp_regfile_sweep_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) ifo ();

    gp_regfile_sweep #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ZERO_REG(0)) u_dut_z (
        .clock(clock), .reset(reset), .bus(ifz)
    );
    gp_regfile_sweep #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ZERO_REG(1)) u_dut_o (
        .clock(clock), .reset(reset), .bus(ifo)
    );

    // Shared stimulus
    logic          we = 1'b0, re = 1'b0, cs = 1'b0;
    logic [2:0]    wa = '0, ra = '0, aa = '0, ab = '0;
    logic [DW-1:0] wd = '0;

    // Reference model: index 0 -> ZERO_REG=0 instance, 1 -> ZERO_REG=1
    logic [DW-1:0] m [2][DEPTH];
    logic [DW-1:0] e_data [2];
    logic          e_valid [2];
    logic          e_done;
    int            sweep_left;
    int            total = 0;
    int            bad = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] exp_rd(input int z, input logic [2:0] addr);
        logic [DW-1:0] v;
        v = m[z][addr];
`ifdef GPR_WRITE_BYPASS_EN
        if (we && sweep_left == 0 && wa == addr) v = wd;
`endif
        if (z == 1 && addr == 3'd0) v = '0;
        return v;
    endfunction

    task automatic drive();
        ifz.wr_en = we; ifz.wr_addr = wa; ifz.wr_data = wd;
        ifz.bus_rd_en = re; ifz.bus_rd_addr = ra;
        ifz.alu_a_addr = aa; ifz.alu_b_addr = ab; ifz.clear_start = cs;
        ifo.wr_en = we; ifo.wr_addr = wa; ifo.wr_data = wd;
        ifo.bus_rd_en = re; ifo.bus_rd_addr = ra;
        ifo.alu_a_addr = aa; ifo.alu_b_addr = ab; ifo.clear_start = cs;
    endtask

    task automatic model_edge();
        for (int z = 0; z < 2; z++) begin
            if (reset) begin
                e_data[z]  = '0;
                e_valid[z] = 1'b0;
            end else begin
                if (re) e_data[z] = exp_rd(z, ra);
                e_valid[z] = re;
            end
        end
        e_done = 1'b0;
        if (reset) begin
            for (int z = 0; z < 2; z++)
                for (int i = 0; i < DEPTH; i++) m[z][i] = '0;
            sweep_left = 0;
        end else if (sweep_left > 0) begin
            m[0][DEPTH - sweep_left] = '0;
            m[1][DEPTH - sweep_left] = '0;
            sweep_left--;
            e_done = (sweep_left == 0);
        end else begin
            if (we) m[0][wa] = wd;
            if (we && wa != 3'd0) m[1][wa] = wd;
            if (cs) sweep_left = DEPTH;
        end
    endtask

    // One clock: ALU checked mid-cycle, registered outputs after the edge.
    task automatic step();
        drive();
        #1;
        chk("alu_a_z", ifz.alu_a_data, exp_rd(0, aa));
        chk("alu_b_z", ifz.alu_b_data, exp_rd(0, ab));
        chk("alu_a_o", ifo.alu_a_data, exp_rd(1, aa));
        chk("alu_b_o", ifo.alu_b_data, exp_rd(1, ab));
        @(posedge clock);
        #1;
        model_edge();
        chk("rd_data_z", ifz.bus_rd_data, e_data[0]);
        chk("rd_valid_z", ifz.bus_rd_valid, e_valid[0]);
        chk("rd_data_o", ifo.bus_rd_data, e_data[1]);
        chk("rd_valid_o", ifo.bus_rd_valid, e_valid[1]);
        chk("busy_z", ifz.busy, sweep_left != 0);
        chk("busy_o", ifo.busy, sweep_left != 0);
        chk("done_z", ifz.clear_done, e_done);
        chk("done_o", ifo.clear_done, e_done);
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < DEPTH; i += 2) begin
            aa = 3'(i); ab = 3'(i + 1); we = 1'b0;
            drive();
            #1;
            chk(tag, ifz.alu_a_data, exp_rd(0, aa));
            chk(tag, ifz.alu_b_data, exp_rd(0, ab));
            chk(tag, ifo.alu_a_data, exp_rd(1, aa));
            chk(tag, ifo.alu_b_data, exp_rd(1, ab));
        end
    endtask

    task automatic idle_inputs();
        we = 1'b0; re = 1'b0; cs = 1'b0; reset = 1'b0;
    endtask

    initial begin
        int n;
        sweep_left = 0;
        e_done = 1'b0;
        for (int z = 0; z < 2; z++) begin
            e_data[z] = '0; e_valid[z] = 1'b0;
            for (int i = 0; i < DEPTH; i++) m[z][i] = '0;
        end
        drive();
        @(posedge clock);
        #1;

        // Reset, then bus read of r5
        reset = 1'b1; step();
        idle_inputs();
        re = 1'b1; ra = 3'd5; step();
        chk("rst_rd5_data", ifz.bus_rd_data, 32'h00);
        chk("rst_rd5_valid", ifz.bus_rd_valid, 32'd1);
        re = 1'b0; step();
        chk("rst_rd5_pulse", ifz.bus_rd_valid, 32'd0);

        // Write 0xA5 to r3 then read it back on both ALU ports and the bus
        we = 1'b1; wa = 3'd3; wd = 8'hA5; step();
        we = 1'b0; aa = 3'd3; ab = 3'd3; re = 1'b1; ra = 3'd3;
        drive(); #1;
        chk("wr_alu_a", ifz.alu_a_data, 32'hA5);
        chk("wr_alu_b", ifz.alu_b_data, 32'hA5);
        step();
        chk("wr_bus_r3", ifz.bus_rd_data, 32'hA5);
        re = 1'b0;

        // Same-cycle write/read hazard on r2
        we = 1'b1; wa = 3'd2; wd = 8'h11; step();
        wd = 8'h3C; aa = 3'd2; re = 1'b1; ra = 3'd2;
        drive(); #1;
`ifdef GPR_WRITE_BYPASS_EN
        chk("haz_alu", ifz.alu_a_data, 32'h3C);
        step();
        chk("haz_bus", ifz.bus_rd_data, 32'h3C);
`else
        chk("haz_alu", ifz.alu_a_data, 32'h11);
        step();
        chk("haz_bus", ifz.bus_rd_data, 32'h11);
`endif
        idle_inputs();

        // Clear sweep over r0..r7 = 1..8
        for (int i = 0; i < DEPTH; i++) begin
            we = 1'b1; wa = 3'(i); wd = 8'(i + 1); step();
        end
        we = 1'b0; cs = 1'b1; step();
        cs = 1'b0;
        n = 0;
        while (ifz.busy === 1'b1 && n < 20) begin
            re = (n == 2); ra = 3'd7;
            we = 1'b1; wa = 3'(n); wd = 8'hEE;
            step();
            if (n == 2) chk("sweep_rd7", ifz.bus_rd_data, 32'h08);
            n++;
        end
        chk("sweep_len", n, 32'd8);
        idle_inputs();
        step();
        check_all("post_sweep");

        // Reset in the middle of a sweep, then restart
        for (int i = 0; i < DEPTH; i++) begin
            we = 1'b1; wa = 3'(i); wd = 8'h50 + 8'(i); step();
        end
        we = 1'b0; cs = 1'b1; step();
        cs = 1'b0;
        for (int i = 0; i < 4; i++) step();
        reset = 1'b1; step();
        reset = 1'b0;
        chk("midrst_busy", ifz.busy, 32'd0);
        check_all("midrst_zero");
        cs = 1'b1; step();
        chk("midrst_restart", ifz.busy, 32'd1);
        cs = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) step();

        // ZERO_REG: write r0 and r1
        we = 1'b1; wa = 3'd0; wd = 8'hFF; step();
        wa = 3'd1; wd = 8'h77; step();
        we = 1'b0; aa = 3'd0; ab = 3'd1; re = 1'b1; ra = 3'd0;
        drive(); #1;
        chk("zr_alu_r0", ifo.alu_a_data, 32'h00);
        chk("zr_alu_r1", ifo.alu_b_data, 32'h77);
        chk("nzr_alu_r0", ifz.alu_a_data, 32'hFF);
        step();
        chk("zr_bus_r0", ifo.bus_rd_data, 32'h00);
        re = 1'b0;

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            reset = ($urandom_range(0, 99) == 0);
            we = 1'($urandom_range(0, 1));
            wa = 3'($urandom_range(0, 7));
            wd = 8'($urandom_range(0, 255));
            re = 1'($urandom_range(0, 1));
            ra = 3'($urandom_range(0, 7));
            aa = 3'($urandom_range(0, 7));
            ab = 3'($urandom_range(0, 7));
            cs = ($urandom_range(0, 24) == 0);
            step();
        end
        idle_inputs();
        step();
        check_all("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
